// File: rtl/mem_bus_bridge.sv
// rtl/mem_bus_bridge.sv - CPU load/store to single-outstanding bus request bridge
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   mem_rd_req_i/addr_i         CPU load request and byte address
//   mem_rd_data_o               load data, valid in the DONE cycle
//   mem_wr_req_i/sel_i/addr_i/data_i  CPU store request, byte lanes, address, data
//   hold_flag_o                 pipeline stall request (combinational)
//   err_o                       one-cycle pulse when a transaction times out
//   bus_req_o/we_o/addr_o/wdata_o/sel_o  registered bus request fields
//   bus_gnt_i                   slave accepted the request
//   bus_rvalid_i/bus_rdata_i    response (read data or write acknowledge)
module mem_bus_bridge #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_rd_req_i,
    input  logic [31:0] mem_rd_addr_i,
    output logic [31:0] mem_rd_data_o,
    input  logic        mem_wr_req_i,
    input  logic [3:0]  mem_wr_sel_i,
    input  logic [31:0] mem_wr_addr_i,
    input  logic [31:0] mem_wr_data_i,
    output logic        hold_flag_o,
    output logic        err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_sel_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    state_t        state;
    logic [CW-1:0] tmo_cnt;
    logic          pend_rd;
    logic [31:0]   pend_addr;

    // A store with no byte lanes enabled is a no-op: it never reaches the bus.
    logic wr_go;
    assign wr_go = mem_wr_req_i && (mem_wr_sel_i != 4'b0000);

    // True on the TIMEOUT-th cycle spent in REQ+WAIT.
    logic tmo_hit;
    assign tmo_hit = (tmo_cnt == CW'(TIMEOUT - 1));

    always_comb begin
        hold_flag_o = 1'b0;
        if (state == S_IDLE && (mem_rd_req_i || wr_go)) hold_flag_o = 1'b1;
        if (state == S_REQ || state == S_WAIT)          hold_flag_o = 1'b1;
        // Keeps the CPU stalled across the write's DONE when a read is queued.
        if (pend_rd)                                    hold_flag_o = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            tmo_cnt       <= '0;
            pend_rd       <= 1'b0;
            pend_addr     <= '0;
            mem_rd_data_o <= '0;
            err_o         <= 1'b0;
            bus_req_o     <= 1'b0;
            bus_we_o      <= 1'b0;
            bus_addr_o    <= '0;
            bus_wdata_o   <= '0;
            bus_sel_o     <= 4'b0000;
        end else begin
            err_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (wr_go) begin
                        // Write goes first; a concurrent load is queued behind it.
                        state       <= S_REQ;
                        tmo_cnt     <= '0;
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= 1'b1;
                        bus_addr_o  <= {mem_wr_addr_i[31:2], 2'b00};
                        bus_wdata_o <= mem_wr_data_i;
                        bus_sel_o   <= mem_wr_sel_i;
                        pend_rd     <= mem_rd_req_i;
                        pend_addr   <= mem_rd_addr_i;
                    end else if (mem_rd_req_i) begin
                        state       <= S_REQ;
                        tmo_cnt     <= '0;
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= 1'b0;
                        bus_addr_o  <= {mem_rd_addr_i[31:2], 2'b00};
                        bus_wdata_o <= '0;
                        bus_sel_o   <= 4'hF;
                    end
                end
                S_REQ: begin
                    if (tmo_hit) begin
                        state         <= S_DONE;
                        err_o         <= 1'b1;
                        mem_rd_data_o <= '0;
                        bus_req_o     <= 1'b0;
                        pend_rd       <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        if (bus_gnt_i) begin
                            state     <= S_WAIT;
                            bus_req_o <= 1'b0;
                        end
                    end
                end
                S_WAIT: begin
                    // A response arriving on the last allowed cycle still completes.
                    if (bus_rvalid_i) begin
                        state <= S_DONE;
                        if (!bus_we_o) mem_rd_data_o <= bus_rdata_i;
                    end else if (tmo_hit) begin
                        state         <= S_DONE;
                        err_o         <= 1'b1;
                        mem_rd_data_o <= '0;
                        pend_rd       <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    // Queued read launches straight from DONE; new CPU requests
                    // are only looked at once back in IDLE.
                    if (pend_rd) begin
                        state       <= S_REQ;
                        tmo_cnt     <= '0;
                        pend_rd     <= 1'b0;
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= 1'b0;
                        bus_addr_o  <= {pend_addr[31:2], 2'b00};
                        bus_wdata_o <= '0;
                        bus_sel_o   <= 4'hF;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_bridge.sv
// tb/tb_mem_bus_bridge.sv - directed self-checking bench for mem_bus_bridge
module tb_mem_bus_bridge;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_rd_req_i;
    logic [31:0] mem_rd_addr_i;
    logic [31:0] mem_rd_data_o;
    logic        mem_wr_req_i;
    logic [3:0]  mem_wr_sel_i;
    logic [31:0] mem_wr_addr_i;
    logic [31:0] mem_wr_data_i;
    logic        hold_flag_o;
    logic        err_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_sel_o;
    logic        bus_gnt_i;
    logic        bus_rvalid_i;
    logic [31:0] bus_rdata_i;

    int checks = 0;
    int errors = 0;

    mem_bus_bridge #(.TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_rd_req_i (mem_rd_req_i),
        .mem_rd_addr_i(mem_rd_addr_i),
        .mem_rd_data_o(mem_rd_data_o),
        .mem_wr_req_i (mem_wr_req_i),
        .mem_wr_sel_i (mem_wr_sel_i),
        .mem_wr_addr_i(mem_wr_addr_i),
        .mem_wr_data_i(mem_wr_data_i),
        .hold_flag_o  (hold_flag_o),
        .err_o        (err_o),
        .bus_req_o    (bus_req_o),
        .bus_we_o     (bus_we_o),
        .bus_addr_o   (bus_addr_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_sel_o    (bus_sel_o),
        .bus_gnt_i    (bus_gnt_i),
        .bus_rvalid_i (bus_rvalid_i),
        .bus_rdata_i  (bus_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int n;
    int early_err;

    initial begin
        rst = 1'b1;
        mem_rd_req_i = 0; mem_rd_addr_i = 0;
        mem_wr_req_i = 0; mem_wr_sel_i = 0; mem_wr_addr_i = 0; mem_wr_data_i = 0;
        bus_gnt_i = 0; bus_rvalid_i = 0; bus_rdata_i = 0;
        tick(); tick();
        chk("rst_bus_req", 32'(bus_req_o), 0);
        chk("rst_err", 32'(err_o), 0);
        chk("rst_hold", 32'(hold_flag_o), 0);
        chk("rst_rdata", mem_rd_data_o, 0);
        rst = 1'b0;
        tick();

        // Read 0x100, minimum latency
        mem_rd_req_i = 1; mem_rd_addr_i = 32'h100; #1;
        chk("rd_c0_hold", 32'(hold_flag_o), 1);
        tick();
        chk("rd_c1_req", 32'(bus_req_o), 1);
        chk("rd_c1_addr", bus_addr_o, 32'h100);
        chk("rd_c1_sel", 32'(bus_sel_o), 32'hF);
        chk("rd_c1_we", 32'(bus_we_o), 0);
        chk("rd_c1_hold", 32'(hold_flag_o), 1);
        bus_gnt_i = 1;
        tick();
        bus_gnt_i = 0;
        chk("rd_c2_req", 32'(bus_req_o), 0);
        chk("rd_c2_hold", 32'(hold_flag_o), 1);
        bus_rvalid_i = 1; bus_rdata_i = 32'hDEADBEEF;
        tick();
        bus_rvalid_i = 0; bus_rdata_i = 0;
        chk("rd_c3_hold", 32'(hold_flag_o), 0);
        chk("rd_c3_data", mem_rd_data_o, 32'hDEADBEEF);
        chk("rd_c3_err", 32'(err_o), 0);
        mem_rd_req_i = 0;
        tick();
        chk("rd_c4_hold", 32'(hold_flag_o), 0);

        // Store 0x203 sel 0011, grant delayed 3 cycles
        mem_wr_req_i = 1; mem_wr_addr_i = 32'h203; mem_wr_sel_i = 4'b0011; mem_wr_data_i = 32'h1234; #1;
        chk("wr_c0_hold", 32'(hold_flag_o), 1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("wr_req_held", 32'(bus_req_o), 1);
            chk("wr_addr", bus_addr_o, 32'h200);
            chk("wr_we", 32'(bus_we_o), 1);
            chk("wr_sel", 32'(bus_sel_o), 32'h3);
            chk("wr_wdata", bus_wdata_o, 32'h1234);
        end
        tick();
        chk("wr_c4_req", 32'(bus_req_o), 1);
        bus_gnt_i = 1;
        tick();
        bus_gnt_i = 0;
        chk("wr_c5_req", 32'(bus_req_o), 0);
        chk("wr_c5_hold", 32'(hold_flag_o), 1);
        bus_rvalid_i = 1;
        tick();
        bus_rvalid_i = 0;
        chk("wr_done_hold", 32'(hold_flag_o), 0);
        chk("wr_keeps_rdata", mem_rd_data_o, 32'hDEADBEEF);
        mem_wr_req_i = 0; mem_wr_sel_i = 0;
        tick();

        // Simultaneous store 0x10 and load 0x20
        mem_wr_req_i = 1; mem_wr_addr_i = 32'h10; mem_wr_sel_i = 4'hF; mem_wr_data_i = 32'hA5A5A5A5;
        mem_rd_req_i = 1; mem_rd_addr_i = 32'h20; #1;
        chk("sim_c0_hold", 32'(hold_flag_o), 1);
        tick();
        chk("sim_c1_we", 32'(bus_we_o), 1);
        chk("sim_c1_addr", bus_addr_o, 32'h10);
        chk("sim_c1_hold", 32'(hold_flag_o), 1);
        bus_gnt_i = 1;
        tick();
        bus_gnt_i = 0;
        chk("sim_c2_hold", 32'(hold_flag_o), 1);
        bus_rvalid_i = 1;
        tick();
        bus_rvalid_i = 0;
        chk("sim_c3_hold", 32'(hold_flag_o), 1);
        chk("sim_c3_req", 32'(bus_req_o), 0);
        tick();
        chk("sim_c4_req", 32'(bus_req_o), 1);
        chk("sim_c4_we", 32'(bus_we_o), 0);
        chk("sim_c4_addr", bus_addr_o, 32'h20);
        chk("sim_c4_sel", 32'(bus_sel_o), 32'hF);
        chk("sim_c4_hold", 32'(hold_flag_o), 1);
        bus_gnt_i = 1;
        tick();
        bus_gnt_i = 0;
        chk("sim_c5_hold", 32'(hold_flag_o), 1);
        bus_rvalid_i = 1; bus_rdata_i = 32'hCAFEF00D;
        tick();
        bus_rvalid_i = 0; bus_rdata_i = 0;
        chk("sim_c6_hold", 32'(hold_flag_o), 0);
        chk("sim_c6_data", mem_rd_data_o, 32'hCAFEF00D);
        mem_wr_req_i = 0; mem_wr_sel_i = 0; mem_rd_req_i = 0;
        tick();
        chk("sim_idle_req", 32'(bus_req_o), 0);

        // Reset asserted while in WAIT
        mem_rd_req_i = 1; mem_rd_addr_i = 32'h80;
        tick();
        bus_gnt_i = 1;
        tick();
        bus_gnt_i = 0;
        chk("rstw_in_wait_hold", 32'(hold_flag_o), 1);
        rst = 1'b1; mem_rd_req_i = 0; #1;
        chk("rstw_async_data", mem_rd_data_o, 0);
        chk("rstw_async_hold", 32'(hold_flag_o), 0);
        chk("rstw_async_req", 32'(bus_req_o), 0);
        tick();
        rst = 1'b0;
        bus_rvalid_i = 1; bus_rdata_i = 32'h55555555;
        tick();
        bus_rvalid_i = 0; bus_rdata_i = 0;
        chk("rstw_late_rvalid_data", mem_rd_data_o, 0);
        chk("rstw_late_rvalid_hold", 32'(hold_flag_o), 0);
        mem_rd_req_i = 1; mem_rd_addr_i = 32'h84; #1;
        tick();
        chk("rstw_new_req", 32'(bus_req_o), 1);
        chk("rstw_new_addr", bus_addr_o, 32'h84);
        bus_gnt_i = 1;
        tick();
        bus_gnt_i = 0;
        bus_rvalid_i = 1; bus_rdata_i = 32'h11223344;
        tick();
        bus_rvalid_i = 0; bus_rdata_i = 0;
        chk("rstw_new_data", mem_rd_data_o, 32'h11223344);
        chk("rstw_new_hold", 32'(hold_flag_o), 0);
        mem_rd_req_i = 0;
        tick();

        // Store with sel 0: no transaction, no stall
        mem_wr_req_i = 1; mem_wr_addr_i = 32'h300; mem_wr_sel_i = 4'b0000; mem_wr_data_i = 32'hFFFF; #1;
        chk("sel0_c0_hold", 32'(hold_flag_o), 0);
        tick();
        chk("sel0_c1_req", 32'(bus_req_o), 0);
        chk("sel0_c1_hold", 32'(hold_flag_o), 0);
        tick();
        chk("sel0_c2_req", 32'(bus_req_o), 0);
        mem_wr_req_i = 0;
        tick();

        // Read with no grant: timeout after TIMEOUT cycles in REQ
        mem_rd_req_i = 1; mem_rd_addr_i = 32'h40; #1;
        n = 0; early_err = 0;
        while (hold_flag_o === 1'b1 && n < 40) begin
            if (err_o === 1'b1) early_err++;
            n++;
            tick();
        end
        chk("tmo_hold_cycles", 32'(n), 32'(TIMEOUT + 1));
        chk("tmo_no_early_err", 32'(early_err), 0);
        chk("tmo_err_pulse", 32'(err_o), 1);
        chk("tmo_rdata_zero", mem_rd_data_o, 0);
        chk("tmo_bus_req", 32'(bus_req_o), 0);
        mem_rd_req_i = 0;
        tick();
        chk("tmo_err_cleared", 32'(err_o), 0);
        chk("tmo_idle_hold", 32'(hold_flag_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_bridge.md
MEM_BUS_BRIDGE -- requirements
Module: mem_bus_bridge

Interface
REQ-001 Parameter TIMEOUT, default 16, max cycles spent in REQ+WAIT before abort.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 mem_rd_req_i  in  1  CPU load request.
REQ-006 mem_rd_addr_i  in  32  load byte address.
REQ-007 mem_rd_data_o  out  32  load data; valid in DONE.
REQ-008 mem_wr_req_i  in  1  CPU store request.
REQ-009 mem_wr_sel_i  in  4  store byte lanes.
REQ-010 mem_wr_addr_i / mem_wr_data_i  in  32 each  store address / data.
REQ-011 hold_flag_o  out  1  pipeline stall request to ctrl.
REQ-012 err_o  out  1  one-cycle pulse on bus timeout.
REQ-013 bus_req_o  out  1  bus request, held until grant.
REQ-014 bus_we_o  out  1  1 = write transaction.
REQ-015 bus_addr_o / bus_wdata_o  out  32 each  word-aligned address / write data.
REQ-016 bus_sel_o  out  4  byte lanes; 4'hF for reads.
REQ-017 bus_gnt_i  in  1  slave accepted request.
REQ-018 bus_rvalid_i / bus_rdata_i  in  1 / 32  response (read data or write ack).

Function
REQ-019 FSM states IDLE, REQ, WAIT, DONE; one outstanding transaction.
REQ-020 IDLE: rd or wr request sampled -> REQ next edge; bus_* registered, bus_req_o=1 from next cycle.
REQ-021 REQ: bus_req_o/addr/we/sel/wdata stable; bus_gnt_i=1 -> WAIT, bus_req_o=0 next cycle.
REQ-022 WAIT: bus_rvalid_i=1 -> DONE; reads capture bus_rdata_i into mem_rd_data_o; rvalid ignored outside WAIT.
REQ-023 DONE: one cycle, hold_flag_o=0, then IDLE; request present in DONE is not restarted.
REQ-024 hold_flag_o (combinational) = (IDLE and (rd_req or wr_req and sel!=0)) or REQ or WAIT, or pending read flag set.
REQ-025 bus_addr_o = {addr[31:2],2'b00}; addr[1:0] ignored.
REQ-026 Simultaneous rd and wr in IDLE: write issued first, pending read latched, read issued from DONE->REQ directly; hold stays 1 until read DONE.
REQ-027 Store with mem_wr_sel_i=0: no bus transaction, no stall.
REQ-028 Timeout counter cleared entering REQ, increments each REQ/WAIT cycle; reaching TIMEOUT -> DONE, err_o=1 that cycle, mem_rd_data_o=0, bus_req_o=0, pending read dropped.
REQ-029 Minimum latency: req cycle 0, gnt cycle 1, rvalid cycle 2, DONE cycle 3 (hold high cycles 0-2).

Reset
REQ-030 rst=1 asynchronously: state IDLE, all outputs 0 (mem_rd_data_o=0, hold_flag_o=0 unless request present, bus_req_o=0, err_o=0), counter and pending flag cleared; aborts any in-flight transaction mid-operation.

Verification
REQ-031 Read 0x100 with gnt cycle 1, rvalid+rdata 0xDEADBEEF cycle 2 -> bus_addr_o 0x100, bus_sel_o 4'hF, hold 1 cycles 0-2, mem_rd_data_o 0xDEADBEEF cycle 3, hold 0.
REQ-032 Store addr 0x203, sel 4'b0011, data 0x1234, gnt delayed 3 cycles -> bus_req_o held, bus_addr_o 0x200, bus_we_o 1, DONE after rvalid.
REQ-033 Simultaneous store 0x10 and load 0x20 -> write transaction then read transaction, hold continuous until read DONE.
REQ-034 Read, no gnt for 16 cycles -> err_o pulse, mem_rd_data_o 0, return to IDLE.
REQ-035 rst asserted while in WAIT -> outputs zero immediately, later rvalid ignored, next request starts cleanly.
REQ-036 Store with sel 0 -> no bus_req_o, hold_flag_o 0.
